// File: rtl/tqvp_stevej_wdt_ctrl.sv
// Watchdog timer peripheral for the TinyQV bus: one shared down-counter sequenced
// through IDLE/RUN/WARN/BITE, reloaded by software-key or hardware-pin kicks.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | watchdog disabled, count held
// ST_RUN  | counting down, above the warning threshold
// ST_WARN | counting down, at/below threshold; warn output asserted
// ST_BITE | bite output held for BITE_CYCLES clocks, kicks ignored
module tqvp_stevej_wdt_ctrl #(
   parameter int unsigned PRESCALE    = 64,
   parameter int unsigned BITE_CYCLES = 16,
   parameter logic [7:0]  KICK_KEY    = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BW = (BITE_CYCLES > 1) ? $clog2(BITE_CYCLES) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
   localparam logic [BW-1:0] BITE_LAST = BW'(BITE_CYCLES - 1);

   localparam logic [5:0] ADDR_CTRL    = 6'h00;
   localparam logic [5:0] ADDR_TIMEOUT = 6'h04;
   localparam logic [5:0] ADDR_KICK    = 6'h08;
   localparam logic [5:0] ADDR_COUNT   = 6'h0C;
   localparam logic [5:0] ADDR_STATUS  = 6'h10;
   localparam logic [5:0] ADDR_WARN    = 6'h14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WARN = 2'd2,
      ST_BITE = 2'd3
   } state_t;

   // configuration registers
   logic        en_q, irq_en_q, lock_q, hwk_en_q;
   logic [31:0] timeout_q, warn_thr_q;
   logic        hw_prev_q;
   logic        irq_q;

   // sequencer registers
   state_t          state_q, state_d;
   logic [31:0]     count_q, count_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [BW-1:0]   bite_cnt_q, bite_cnt_d;
   logic            wpend_q, bpend_q;
   logic            bite_q, warn_out_q, run_q;
   logic            warn_set, bite_set;

   logic        wr_any;
   logic [31:0] wmask;
   logic        ctrl_wr, tmo_wr, kick_wr, status_wr, warn_wr;
   logic        en_rise, en_fall;
   logic        sw_kick, hw_kick, kick;
   logic        tick;
   logic [31:0] tmo_eff, count_dec;
   logic        unused_inputs;

   assign unused_inputs = ^{data_read_n, ui_in[7:6], ui_in[4:0]};

   assign wr_any = (data_write_n != 2'b11);
   assign wmask  = {{16{data_write_n == 2'b10}},
                    {8{(data_write_n == 2'b01) || (data_write_n == 2'b10)}},
                    {8{wr_any}}};

   assign ctrl_wr   = wr_any && (address == ADDR_CTRL);
   assign tmo_wr    = wr_any && (address == ADDR_TIMEOUT);
   assign kick_wr   = wr_any && (address == ADDR_KICK);
   assign status_wr = wr_any && (address == ADDR_STATUS);
   assign warn_wr   = wr_any && (address == ADDR_WARN);

   // EN is frozen by LOCK; the lock bit seen here is the pre-write value
   assign en_rise = ctrl_wr && !lock_q && data_in[0] && !en_q;
   assign en_fall = ctrl_wr && !lock_q && !data_in[0];

   assign sw_kick = kick_wr && (data_in[7:0] == KICK_KEY);
   assign hw_kick = hwk_en_q && ui_in[5] && !hw_prev_q;
   assign kick    = sw_kick || hw_kick;

   assign tick      = (presc_q == PRESC_MAX);
   assign tmo_eff   = (timeout_q == 32'd0) ? 32'd1 : timeout_q;
   assign count_dec = count_q - 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q       <= 1'b0;
         irq_en_q   <= 1'b0;
         lock_q     <= 1'b0;
         hwk_en_q   <= 1'b0;
         timeout_q  <= 32'd0;
         warn_thr_q <= 32'd0;
         hw_prev_q  <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         hw_prev_q <= ui_in[5];
         irq_q     <= irq_en_q && (wpend_q || bpend_q);
         if (ctrl_wr) begin
            irq_en_q <= data_in[1];
            hwk_en_q <= data_in[3];
            lock_q   <= lock_q | data_in[2];
            if (!lock_q) en_q <= data_in[0];
         end
         if (tmo_wr && !lock_q)
            timeout_q <= (timeout_q & ~wmask) | (data_in & wmask);
         if (warn_wr && !lock_q)
            warn_thr_q <= (warn_thr_q & ~wmask) | (data_in & wmask);
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      presc_d    = presc_q;
      bite_cnt_d = bite_cnt_q;
      warn_set   = 1'b0;
      bite_set   = 1'b0;
      if (en_fall) begin
         state_d = ST_IDLE;
         presc_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en_rise) begin
                  state_d = ST_RUN;
                  count_d = tmo_eff;
                  presc_d = '0;
               end
            end
            ST_RUN, ST_WARN: begin
               if (kick) begin
                  state_d = ST_RUN;
                  count_d = tmo_eff;
                  presc_d = '0;
               end else if (tick) begin
                  presc_d = '0;
                  count_d = count_dec;
                  if (count_dec == 32'd0) begin
                     state_d    = ST_BITE;
                     bite_cnt_d = BITE_LAST;
                     bite_set   = 1'b1;
                     warn_set   = (state_q == ST_RUN);
                  end else if ((state_q == ST_RUN) && (count_dec <= warn_thr_q)) begin
                     state_d  = ST_WARN;
                     warn_set = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            ST_BITE: begin
               if (bite_cnt_q == '0) begin
                  presc_d = '0;
                  if (en_q) begin
                     state_d = ST_RUN;
                     count_d = tmo_eff;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  bite_cnt_d = bite_cnt_q - BW'(1);
               end
            end
         endcase
      end
   end

   // outputs are registered from the next state so they change with state_q
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         count_q    <= 32'd0;
         presc_q    <= '0;
         bite_cnt_q <= '0;
         wpend_q    <= 1'b0;
         bpend_q    <= 1'b0;
         bite_q     <= 1'b0;
         warn_out_q <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         presc_q    <= presc_d;
         bite_cnt_q <= bite_cnt_d;
         wpend_q    <= (wpend_q && !(status_wr && data_in[0])) || warn_set;
         bpend_q    <= (bpend_q && !(status_wr && data_in[1])) || bite_set;
         bite_q     <= (state_d == ST_BITE);
         warn_out_q <= (state_d == ST_WARN);
         run_q      <= (state_d == ST_RUN) || (state_d == ST_WARN);
      end
   end

   always_comb begin
      data_out = 32'd0;
      case (address)
         ADDR_CTRL:    data_out = {28'd0, hwk_en_q, lock_q, irq_en_q, en_q};
         ADDR_TIMEOUT: data_out = timeout_q;
         ADDR_COUNT:   data_out = count_q;
         ADDR_STATUS:  data_out = {27'd0, state_q, run_q, bpend_q, wpend_q};
         ADDR_WARN:    data_out = warn_thr_q;
         default:      data_out = 32'd0;
      endcase
   end

   assign uo_out         = {4'b0000, run_q, warn_out_q, bite_q, 1'b0};
   assign data_ready     = 1'b1;
   assign user_interrupt = irq_q;

endmodule

// File: tb/tb_tqvp_stevej_wdt_ctrl.sv
// Bench for the watchdog controller: directed scenarios plus a randomized kick
// run compared against an elapsed-time model of the countdown.
module tb_tqvp_stevej_wdt_ctrl;

   localparam int P  = 4;
   localparam int BC = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ui_in;
   logic [7:0]  uo_out;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;
   logic        user_interrupt;

   int checks   = 0;
   int failures = 0;

   tqvp_stevej_wdt_ctrl #(.PRESCALE(P), .BITE_CYCLES(BC), .KICK_KEY(8'hA5)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ui_in          (ui_in),
      .uo_out         (uo_out),
      .address        (address),
      .data_in        (data_in),
      .data_write_n   (data_write_n),
      .data_read_n    (data_read_n),
      .data_out       (data_out),
      .data_ready     (data_ready),
      .user_interrupt (user_interrupt)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0;
      ui_in = 8'h00;
      address = 6'h00;
      data_in = 32'd0;
      data_write_n = 2'b11;
      data_read_n = 2'b11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
      @(negedge clk);
      address = a;
      data_in = d;
      data_write_n = sz;
      @(posedge clk);
      #1;
      data_write_n = 2'b11;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [5:0] a, output logic [31:0] v);
      address = a;
      #1;
      v = data_out;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      do_reset();
      peek(6'h00, v);
      checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_ctrl got %h want 0", v); end
      peek(6'h0C, v);
      checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_count got %h want 0", v); end
      peek(6'h10, v);
      checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_status got %h want 0", v); end
      checks++; if (uo_out !== 8'h00) begin failures++; $display("FAIL reset_uo got %h want 00", uo_out); end
      checks++; if (user_interrupt !== 1'b0) begin failures++; $display("FAIL reset_irq got %b want 0", user_interrupt); end
      checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL data_ready got %b want 1", data_ready); end
   endtask

   task automatic test_byte_enables();
      logic [31:0] v;
      wr(6'h04, 32'h12345678, 2'b10);
      wr(6'h04, 32'hAABBCCDD, 2'b00);
      peek(6'h04, v);
      checks++; if (v !== 32'h123456DD) begin failures++; $display("FAIL be_8bit got %h want 123456dd", v); end
      wr(6'h04, 32'h11112222, 2'b01);
      peek(6'h04, v);
      checks++; if (v !== 32'h12342222) begin failures++; $display("FAIL be_16bit got %h want 12342222", v); end
      wr(6'h08, 32'h000000A5, 2'b10);
      peek(6'h08, v);
      checks++; if (v !== 32'd0) begin failures++; $display("FAIL kick_read got %h want 0", v); end
   endtask

   task automatic test_timeout_sequence();
      logic [31:0] v;
      int highs;
      wr(6'h04, 32'd10, 2'b10);
      wr(6'h14, 32'd3, 2'b10);
      wr(6'h00, 32'h3, 2'b00);
      peek(6'h0C, v);
      checks++; if (v !== 32'd10) begin failures++; $display("FAIL load_count got %0d want 10", v); end
      checks++; if (uo_out !== 8'h08) begin failures++; $display("FAIL run_uo got %h want 08", uo_out); end
      step(27);
      peek(6'h0C, v);
      checks++; if (v !== 32'd4) begin failures++; $display("FAIL count_pre_warn got %0d want 4", v); end
      checks++; if (uo_out !== 8'h08) begin failures++; $display("FAIL pre_warn_uo got %h want 08", uo_out); end
      step(1);
      checks++; if (uo_out !== 8'h0C) begin failures++; $display("FAIL warn_uo got %h want 0c", uo_out); end
      peek(6'h10, v);
      checks++; if (v[0] !== 1'b1) begin failures++; $display("FAIL warn_pend got %b want 1", v[0]); end
      checks++; if (user_interrupt !== 1'b0) begin failures++; $display("FAIL irq_latency got %b want 0", user_interrupt); end
      step(1);
      checks++; if (user_interrupt !== 1'b1) begin failures++; $display("FAIL irq_warn got %b want 1", user_interrupt); end
      step(10);
      checks++; if (uo_out !== 8'h0C) begin failures++; $display("FAIL pre_bite_uo got %h want 0c", uo_out); end
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (uo_out[1]) highs++;
         if (i == 0) begin
            checks++; if (uo_out !== 8'h02) begin failures++; $display("FAIL bite_start_uo got %h want 02", uo_out); end
         end
      end
      checks++; if (highs != BC) begin failures++; $display("FAIL bite_width got %0d want %0d", highs, BC); end
      peek(6'h0C, v);
      checks++; if (v !== 32'd10) begin failures++; $display("FAIL post_bite_count got %0d want 10", v); end
      peek(6'h10, v);
      checks++; if (v !== 32'h0F) begin failures++; $display("FAIL post_bite_status got %h want 0f", v); end
   endtask

   task automatic test_kick();
      logic [31:0] v;
      wr(6'h08, 32'h0000005A, 2'b00);
      peek(6'h0C, v);
      checks++; if (v !== 32'd9) begin failures++; $display("FAIL bad_key got %0d want 9", v); end
      wr(6'h08, 32'h000000A5, 2'b00);
      peek(6'h0C, v);
      checks++; if (v !== 32'd10) begin failures++; $display("FAIL good_key got %0d want 10", v); end
      step(3);
      peek(6'h0C, v);
      checks++; if (v !== 32'd10) begin failures++; $display("FAIL presc_clear_a got %0d want 10", v); end
      step(1);
      peek(6'h0C, v);
      checks++; if (v !== 32'd9) begin failures++; $display("FAIL presc_clear_b got %0d want 9", v); end
      step(3);
      wr(6'h08, 32'h000000A5, 2'b10);
      peek(6'h0C, v);
      checks++; if (v !== 32'd10) begin failures++; $display("FAIL kick_vs_tick got %0d want 10", v); end
      step(3);
      peek(6'h0C, v);
      checks++; if (v !== 32'd10) begin failures++; $display("FAIL kick_vs_tick_hold got %0d want 10", v); end
      step(1);
      peek(6'h0C, v);
      checks++; if (v !== 32'd9) begin failures++; $display("FAIL kick_vs_tick_next got %0d want 9", v); end
   endtask

   task automatic test_hwkick();
      logic [31:0] v;
      bit seen;
      wr(6'h10, 32'h3, 2'b00);
      peek(6'h10, v);
      checks++; if (v[1:0] !== 2'b00) begin failures++; $display("FAIL w1c_both got %b want 00", v[1:0]); end
      wr(6'h00, 32'hB, 2'b00);
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         step(1);
         if (uo_out[2]) seen = 1;
      end
      checks++; if (!seen) begin failures++; $display("FAIL wait_warn got timeout want warn"); end
      @(negedge clk);
      ui_in[5] = 1'b1;
      step(1);
      peek(6'h10, v);
      checks++; if (v !== 32'h0D) begin failures++; $display("FAIL hwkick_status got %h want 0d", v); end
      checks++; if (uo_out !== 8'h08) begin failures++; $display("FAIL hwkick_uo got %h want 08", uo_out); end
      peek(6'h0C, v);
      checks++; if (v !== 32'd10) begin failures++; $display("FAIL hwkick_count got %0d want 10", v); end
      @(negedge clk);
      ui_in[5] = 1'b0;
      wr(6'h10, 32'h1, 2'b00);
      peek(6'h10, v);
      checks++; if (v[0] !== 1'b0) begin failures++; $display("FAIL w1c_warn got %b want 0", v[0]); end
      checks++; if (user_interrupt !== 1'b1) begin failures++; $display("FAIL irq_hold got %b want 1", user_interrupt); end
      step(1);
      checks++; if (user_interrupt !== 1'b0) begin failures++; $display("FAIL irq_drop got %b want 0", user_interrupt); end
   endtask

   task automatic test_lock();
      logic [31:0] v;
      bit seen;
      wr(6'h00, 32'h7, 2'b00);
      wr(6'h00, 32'h0, 2'b00);
      peek(6'h00, v);
      checks++; if (v !== 32'h5) begin failures++; $display("FAIL lock_ctrl got %h want 5", v); end
      wr(6'h04, 32'd5, 2'b10);
      peek(6'h04, v);
      checks++; if (v !== 32'd10) begin failures++; $display("FAIL lock_timeout got %0d want 10", v); end
      checks++; if (uo_out[3] !== 1'b1) begin failures++; $display("FAIL lock_running got %b want 1", uo_out[3]); end
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         step(1);
         if (uo_out[1]) seen = 1;
      end
      checks++; if (!seen) begin failures++; $display("FAIL wait_bite got timeout want bite"); end
      step(3);
      rst_n = 1'b0;
      #1;
      checks++; if (uo_out !== 8'h00) begin failures++; $display("FAIL async_reset_uo got %h want 00", uo_out); end
      peek(6'h00, v);
      checks++; if (v !== 32'd0) begin failures++; $display("FAIL reset_lock got %h want 0", v); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_timeout_zero();
      logic [31:0] v;
      wr(6'h00, 32'h1, 2'b00);
      peek(6'h0C, v);
      checks++; if (v !== 32'd1) begin failures++; $display("FAIL zero_tmo_count got %0d want 1", v); end
      step(3);
      checks++; if (uo_out !== 8'h08) begin failures++; $display("FAIL zero_tmo_run got %h want 08", uo_out); end
      step(1);
      checks++; if (uo_out !== 8'h02) begin failures++; $display("FAIL zero_tmo_bite got %h want 02", uo_out); end
   endtask

   // Elapsed-time model: e edges after a load, count = tmo - e/P until it hits 0,
   // then BC cycles of bite, then an automatic reload.
   int m_tmo, m_warn, m_c, m_rl;
   bit m_wp, m_bp, m_irq;

   function automatic int st_at(input int e);
      if (e >= m_tmo * P) return 3;
      if (e >= P && (m_tmo - e / P) <= m_warn) return 2;
      return 1;
   endfunction

   function automatic int cnt_at(input int e);
      if (e >= m_tmo * P) return 0;
      return m_tmo - e / P;
   endfunction

   task automatic test_random(input int cycles);
      logic [31:0] v, d, exp_status;
      logic [7:0]  exp_uo;
      logic [1:0]  sz, sb;
      int st, pst, nst, r;
      bit sw_kick, hw_rise, old5;
      logic [1:0] clr;
      do_reset();
      m_tmo  = $urandom_range(1, 8);
      m_warn = $urandom_range(0, 8);
      wr(6'h04, 32'(m_tmo), 2'b10);
      wr(6'h14, 32'(m_warn), 2'b10);
      wr(6'h00, 32'hB, 2'b00);
      m_c = 0; m_rl = 0; m_wp = 0; m_bp = 0; m_irq = 0;
      for (int n = 0; n < cycles; n++) begin
         st = st_at(m_c - m_rl);
         sb = st[1:0];
         exp_status = {27'd0, sb, (st == 1 || st == 2), m_bp, m_wp};
         exp_uo = {4'b0000, (st == 1 || st == 2), (st == 2), (st == 3), 1'b0};
         peek(6'h0C, v);
         checks++; if (v !== 32'(cnt_at(m_c - m_rl))) begin failures++; $display("FAIL rnd_count cyc=%0d got %0d want %0d", m_c, v, cnt_at(m_c - m_rl)); end
         peek(6'h10, v);
         checks++; if (v !== exp_status) begin failures++; $display("FAIL rnd_status cyc=%0d got %h want %h", m_c, v, exp_status); end
         checks++; if (uo_out !== exp_uo) begin failures++; $display("FAIL rnd_uo cyc=%0d got %h want %h", m_c, uo_out, exp_uo); end
         checks++; if (user_interrupt !== m_irq) begin failures++; $display("FAIL rnd_irq cyc=%0d got %b want %b", m_c, user_interrupt, m_irq); end
         @(negedge clk);
         sw_kick = 0;
         clr = 2'b00;
         r = $urandom_range(0, 99);
         sz = 2'($urandom_range(0, 2));
         d = $urandom;
         if (r < 5) begin
            d[7:0] = 8'hA5;
            address = 6'h08; data_in = d; data_write_n = sz;
            sw_kick = 1;
         end else if (r < 8) begin
            if (d[7:0] == 8'hA5) d[7:0] = 8'h5A;
            address = 6'h08; data_in = d; data_write_n = sz;
         end else if (r < 11) begin
            address = 6'h10; data_in = d; data_write_n = sz;
            clr = d[1:0];
         end
         old5 = ui_in[5];
         if ($urandom_range(0, 9) == 0) ui_in[5] = ~ui_in[5];
         hw_rise = ui_in[5] && !old5;
         @(posedge clk);
         #1;
         data_write_n = 2'b11;
         pst = st_at(m_c - m_rl);
         m_c++;
         m_irq = m_wp | m_bp;
         if ((sw_kick || hw_rise) && (pst == 1 || pst == 2)) m_rl = m_c;
         else if (pst == 3 && (m_c - m_rl) == m_tmo * P + BC) m_rl = m_c;
         nst = st_at(m_c - m_rl);
         if (clr[0]) m_wp = 0;
         if (clr[1]) m_bp = 0;
         if (pst == 1 && (nst == 2 || nst == 3)) m_wp = 1;
         if (nst == 3 && pst != 3) m_bp = 1;
      end
   endtask

   initial begin
      test_reset();
      test_byte_enables();
      test_timeout_sequence();
      test_kick();
      test_hwkick();
      test_lock();
      test_timeout_zero();
      for (int k = 0; k < 3; k++) test_random(600);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got stuck want finish");
      $fatal(1, "timeout");
   end

endmodule
